ds3502_wiper_arbiter: RTL
=========================

Name: ds3502_wiper_arbiter

Overview:
Shares one ds3502 write engine among NUM_REQ requesters, e.g. gain-trim loop, host register write and power-up preset. Round-robin arbitration. Each grant runs exactly one load/busy handshake with the engine, then returns a one-cycle ack to the granted requester. Tracks the last successfully written wiper value and flags engine hangs with watchdogs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BUSY_TIMEOUT, 16, max clk cycles from pot_load pulse to pot_busy=1
XFER_TIMEOUT, 200000, max clk cycles pot_busy may stay high for one transaction

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  NUM_REQ  per-requester write request; held high until ack
wdata  in  8*NUM_REQ  wiper value; requester i uses bits [8i+7:8i]
ack  out  NUM_REQ  one-cycle done pulse to granted requester
ack_err  out  1  valid with ack; 1 = transaction aborted by timeout
pot_load  out  1  to ds3502 load
pot_r  out  8  to ds3502 r
pot_busy  in  1  from ds3502 busy
cur_wiper  out  8  last value written successfully
cur_valid  out  1  cur_wiper holds a real write
err_timeout  out  1  sticky; set on any timeout
active  out  1  high from grant to ack, inclusive

Behaviour:
- Reset, active-high, synchronous, overrides everything including mid-transaction:
  - all outputs 0: ack, ack_err, pot_load, pot_r, cur_wiper, cur_valid, err_timeout, active
  - FSM to IDLE; rr pointer to 0; watchdog counter to 0.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE.
- IDLE:
  - Grant only when pot_busy=0 and any req=1.
  - Pick the first set req scanning from ptr upward, wrapping at NUM_REQ-1 to 0.
  - Latch index g and value wdata[g]; pot_r is driven from the latch. active=1. Next state ISSUE.
- ISSUE:
  - pot_load=1 for exactly this one cycle; counter cleared. Next state WAIT_HI.
- WAIT_HI:
  - pot_busy=1 -> WAIT_LO, counter cleared.
  - Counter reaching BUSY_TIMEOUT -> DONE with abort.
- WAIT_LO:
  - pot_busy=0 -> DONE, success.
  - Counter reaching XFER_TIMEOUT -> DONE with abort.
- DONE, one cycle:
  - ack[g]=1. ack_err = abort.
  - On success: cur_wiper<=latched value, cur_valid<=1.
  - On abort: err_timeout<=1; cur_wiper unchanged.
  - ptr <= (g+1) mod NUM_REQ. active=0 next cycle. Next state IDLE.
- pot_r is stable from ISSUE through DONE; pot_load is never high outside ISSUE.
- Minimum latency from grant cycle to ack: 4 cycles plus engine busy time.
- The req/wdata sampling rules:
  - Sampled only in the IDLE grant cycle.
  - wdata changes after grant are ignored.
  - req dropped after grant: transaction still completes and ack still pulses.
  - req dropped before grant: withdraws with no side effect.
- Requester must deassert req in the cycle after ack, or it is eligible again (after others, per round-robin).
- pot_busy high in IDLE (engine still in reset or still finishing): no grant until it falls.
- err_timeout clears only on rst.
- Watchdog counter is 32-bit and saturating; it is compared with ==.

Optional Feature:
Macro SKIP_SAME_EN.
- Defined: in IDLE, if cur_valid=1 and wdata[g]==cur_wiper, no engine transaction.
  - Next cycle goes straight to DONE: ack[g]=1, ack_err=0, ptr advances, pot_load stays 0.
  - Grant→ack latency 1 cycle.
- Not defined: every grant performs a full ISSUE/WAIT_HI/WAIT_LO transaction, even for identical values.

Test Plan:
- Single write: req[1]=1, wdata1=8'h5A; engine model raises busy 1 cycle after load and drops it 100 cycles later -> exactly one pot_load pulse with pot_r=5A; ack[1] pulses once with ack_err=0; cur_wiper=5A, cur_valid=1.
- Contention: req[0..3] all high from ptr=0, each dropped after its own ack -> grant order 0,1,2,3; four load pulses carrying each requester's value; no overlap.
- Round-robin fairness: after serving req2, req2 and req0 both high -> req3 scan finds 0 first, so req0 is served before req2.
- Timeout: engine model never raises busy -> ack pulses with ack_err=1 after BUSY_TIMEOUT (16) cycles; err_timeout=1; cur_wiper unchanged. Repeat with busy stuck high -> abort after XFER_TIMEOUT.
- Reset mid-transaction: rst=1 during WAIT_LO -> next cycle all outputs 0 and FSM IDLE; with pot_busy still high, no grant until pot_busy=0.
- SKIP_SAME_EN defined: write 8'h33, then request 8'h33 again -> second ack arrives 1 cycle after grant with no pot_load. Without the macro the second request produces a second pot_load.

Source files
------------

// File: rtl/ds3502_wiper_arbiter_if.sv
// Bundle between the ds3502 wiper arbiter, its requesters and the ds3502 write engine.
// The arbiter uses the slave modport; the requester/engine side uses master.
interface ds3502_wiper_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] wdata;
  logic [NUM_REQ-1:0]   ack;
  logic                 ack_err;
  logic                 pot_load;
  logic [7:0]           pot_r;
  logic                 pot_busy;
  logic [7:0]           cur_wiper;
  logic                 cur_valid;
  logic                 err_timeout;
  logic                 active;

  modport master (
    output req, wdata, pot_busy,
    input  ack, ack_err, pot_load, pot_r, cur_wiper, cur_valid, err_timeout, active
  );

  modport slave (
    input  req, wdata, pot_busy,
    output ack, ack_err, pot_load, pot_r, cur_wiper, cur_valid, err_timeout, active
  );
endinterface

// File: rtl/ds3502_wiper_arbiter.sv
// Round-robin arbiter sharing one ds3502 write engine; each grant runs one load/busy handshake then acks.
// Optional macro SKIP_SAME_EN: a grant whose value matches cur_wiper acks next cycle without an engine write.
module ds3502_wiper_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16,
  parameter int XFER_TIMEOUT = 200000
) (
  input logic                   clk,
  input logic                   rst,
  ds3502_wiper_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [7:0]    val_q, val_d;
  logic [7:0]    cur_wiper_q, cur_wiper_d;
  logic [31:0]   cnt_q, cnt_d, cnt_inc;
  logic          abort_q, abort_d;
  logic          cur_valid_q, cur_valid_d;
  logic          err_q, err_d;

  logic          grant_vld;
  logic [IW-1:0] scan_idx;
  logic [7:0]    scan_dat;

  // Scan from farthest to nearest so the first set req at or after ptr wins.
  always_comb begin : rr_scan
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    scan_idx  = '0;
    scan_dat  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req[idx]) begin
        grant_vld = 1'b1;
        scan_idx  = IW'(idx);
        scan_dat  = bus.wdata[idx*8 +: 8];
      end
    end
    grant_vld = grant_vld && (state_q == S_IDLE) && !bus.pot_busy;
  end

  assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    ptr_d       = ptr_q;
    val_d       = val_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    cur_wiper_d = cur_wiper_q;
    cur_valid_d = cur_valid_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          g_d     = scan_idx;
          val_d   = scan_dat;
          abort_d = 1'b0;
`ifdef SKIP_SAME_EN
          if (cur_valid_q && (scan_dat == cur_wiper_q)) state_d = S_DONE;
          else                                          state_d = S_ISSUE;
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (bus.pot_busy) begin
          cnt_d   = '0;
          state_d = S_WAIT_LO;
        end else if (cnt_inc == 32'(BUSY_TIMEOUT)) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_LO: begin
        if (!bus.pot_busy) begin
          state_d = S_DONE;
        end else if (cnt_inc == 32'(XFER_TIMEOUT)) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        ptr_d = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
        if (abort_q) begin
          err_d = 1'b1;
        end else begin
          cur_wiper_d = val_q;
          cur_valid_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      g_q         <= '0;
      ptr_q       <= '0;
      val_q       <= '0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      cur_wiper_q <= '0;
      cur_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      ptr_q       <= ptr_d;
      val_q       <= val_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      cur_wiper_q <= cur_wiper_d;
      cur_valid_q <= cur_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    bus.ack = '0;
    if (state_q == S_DONE) bus.ack[g_q] = 1'b1;
  end

  assign bus.ack_err     = (state_q == S_DONE) && abort_q;
  assign bus.pot_load    = (state_q == S_ISSUE);
  assign bus.pot_r       = val_q;
  assign bus.cur_wiper   = cur_wiper_q;
  assign bus.cur_valid   = cur_valid_q;
  assign bus.err_timeout = err_q;
  assign bus.active      = grant_vld || (state_q != S_IDLE);
endmodule
